// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sources from the pipeline stages and the per-stage stall/bubble controls
// returned to them; the controller uses the slave view, the pipeline the master view.
interface pipe_hazard_ctrl_if;
  logic [4:0] D_rs1_i;
  logic [4:0] D_rs2_i;
  logic       D_use_rs1_i;
  logic       D_use_rs2_i;
  logic       E_is_load_i;
  logic       E_need_dstE_i;
  logic [4:0] E_dstE_i;
  logic       E_redirect_i;
  logic       E_csr_trap_i;
  logic       M_mem_req_i;
  logic       M_mem_ready_i;

  logic       PC_stall_o;
  logic       F_stall_o;
  logic       F_bubble_o;
  logic       D_stall_o;
  logic       D_bubble_o;
  logic       E_stall_o;
  logic       E_bubble_o;
  logic       M_stall_o;
  logic       M_bubble_o;

  modport slave (
    input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i,
    input  E_is_load_i, E_need_dstE_i, E_dstE_i, E_redirect_i, E_csr_trap_i,
    input  M_mem_req_i, M_mem_ready_i,
    output PC_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
    output E_stall_o, E_bubble_o, M_stall_o, M_bubble_o
  );

  modport master (
    output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i,
    output E_is_load_i, E_need_dstE_i, E_dstE_i, E_redirect_i, E_csr_trap_i,
    output M_mem_req_i, M_mem_ready_i,
    input  PC_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
    input  E_stall_o, E_bubble_o, M_stall_o, M_bubble_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/flush controller for the 5-stage pipeline: per-stage stall/bubble,
// wait/drain FSM, memory-wait timeout pulse and stall performance counter.
module pipe_hazard_ctrl #(
  parameter int unsigned TRAP_DRAIN  = 2,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  pipe_hazard_ctrl_if.slave    hz,
  output logic                 mem_timeout_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int unsigned DW = (TRAP_DRAIN > 0) ? $clog2(TRAP_DRAIN + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD  = DW'(TRAP_DRAIN);
  localparam logic [15:0]   TIMEOUT_VAL = 16'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_TRAP_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic [15:0]           wait_q, wait_d;
  logic                  fired_q, fired_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic memwait, loaduse;
  logic pc_stall, f_stall, f_bubble, d_stall, d_bubble;
  logic e_stall, e_bubble, m_stall, m_bubble;

  assign memwait = hz.M_mem_req_i & ~hz.M_mem_ready_i;
  assign loaduse = hz.E_is_load_i & hz.E_need_dstE_i & (hz.E_dstE_i != 5'd0) &
                   ((hz.D_use_rs1_i & (hz.D_rs1_i == hz.E_dstE_i)) |
                    (hz.D_use_rs2_i & (hz.D_rs2_i == hz.E_dstE_i)));

  // Reset forces every stage to a bubble so clocks during reset flush the pipe.
  always_comb begin
    pc_stall = 1'b0;
    f_stall  = 1'b0;
    f_bubble = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_stall  = 1'b0;
    e_bubble = 1'b0;
    m_stall  = 1'b0;
    m_bubble = 1'b0;
    if (!rst_n_i) begin
      f_bubble = 1'b1;
      d_bubble = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
    end else if (memwait) begin
      pc_stall = 1'b1;
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_bubble = 1'b1;
    end else if (hz.E_csr_trap_i) begin
      f_bubble = 1'b1;
      d_bubble = 1'b1;
    end else if (state_q == ST_TRAP_DRAIN) begin
      f_bubble = 1'b1;
    end else if (hz.E_redirect_i) begin
      f_bubble = 1'b1;
      d_bubble = 1'b1;
    end else if (loaduse) begin
      pc_stall = 1'b1;
      f_stall  = 1'b1;
      d_bubble = 1'b1;
    end
  end

  // A memory wait freezes the drain count; a pending drain resumes once the wait ends.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (memwait) begin
      state_d = ST_MEM_WAIT;
    end else if (hz.E_csr_trap_i && (TRAP_DRAIN > 0)) begin
      state_d = ST_TRAP_DRAIN;
      drain_d = DRAIN_LOAD;
    end else begin
      case (state_q)
        ST_MEM_WAIT:   state_d = (drain_q != '0) ? ST_TRAP_DRAIN : ST_RUN;
        ST_TRAP_DRAIN: begin
          if (drain_q <= DW'(1)) begin
            state_d = ST_RUN;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        default:       state_d = ST_RUN;
      endcase
    end
  end

  // fired_q keeps a saturated wait counter from re-triggering the timeout.
  always_comb begin
    wait_d      = '0;
    fired_d     = 1'b0;
    timeout_d   = (wait_q == TIMEOUT_VAL) & ~fired_q;
    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(pc_stall);
    if (memwait) begin
      wait_d  = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
      fired_d = fired_q | timeout_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      wait_q      <= '0;
      fired_q     <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      wait_q      <= wait_d;
      fired_q     <= fired_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.PC_stall_o = pc_stall;
  assign hz.F_stall_o  = f_stall;
  assign hz.F_bubble_o = f_bubble;
  assign hz.D_stall_o  = d_stall;
  assign hz.D_bubble_o = d_bubble;
  assign hz.E_stall_o  = e_stall;
  assign hz.E_bubble_o = e_bubble;
  assign hz.M_stall_o  = m_stall;
  assign hz.M_bubble_o = m_bubble;

  assign mem_timeout_o = timeout_q;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with TRAP_DRAIN=2 and MEM_TIMEOUT=4;
// expected control vectors are hand-derived constants.
module tb_pipe_hazard_ctrl;

  // Control vector order: {PC_stall, F_stall, F_bubble, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble}
  localparam logic [8:0] CTL_NONE  = 9'b0_00_00_00_00;
  localparam logic [8:0] CTL_RESET = 9'b0_01_01_01_01;
  localparam logic [8:0] CTL_MEMW  = 9'b1_10_10_10_01;
  localparam logic [8:0] CTL_FD    = 9'b0_01_01_00_00;
  localparam logic [8:0] CTL_F     = 9'b0_01_00_00_00;
  localparam logic [8:0] CTL_LU    = 9'b1_10_01_00_00;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_timeout_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;

  int compared   = 0;
  int mismatched = 0;
  int expCnt     = 0;
  int pulses     = 0;

  pipe_hazard_ctrl_if hzIf ();

  pipe_hazard_ctrl #(
    .TRAP_DRAIN (2),
    .MEM_TIMEOUT(4),
    .CNT_WIDTH  (32)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .hz           (hzIf),
    .mem_timeout_o(mem_timeout_o),
    .state_o      (state_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  wire [8:0] ctl = {hzIf.PC_stall_o, hzIf.F_stall_o, hzIf.F_bubble_o, hzIf.D_stall_o,
                    hzIf.D_bubble_o, hzIf.E_stall_o, hzIf.E_bubble_o, hzIf.M_stall_o,
                    hzIf.M_bubble_o};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic use1,
                               input logic [4:0] rs2, input logic use2,
                               input logic isLoad, input logic needDst, input logic [4:0] dst,
                               input logic redirect, input logic trap,
                               input logic req, input logic ready);
    hzIf.D_rs1_i       = rs1;
    hzIf.D_use_rs1_i   = use1;
    hzIf.D_rs2_i       = rs2;
    hzIf.D_use_rs2_i   = use2;
    hzIf.E_is_load_i   = isLoad;
    hzIf.E_need_dstE_i = needDst;
    hzIf.E_dstE_i      = dst;
    hzIf.E_redirect_i  = redirect;
    hzIf.E_csr_trap_i  = trap;
    hzIf.M_mem_req_i   = req;
    hzIf.M_mem_ready_i = ready;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs are already applied; check this cycle's outputs, then advance one clock.
  task automatic cycle(input string tag, input logic [8:0] expCtl,
                       input logic [1:0] expState, input logic expTo);
    #1;
    checkOutput({tag, ".ctl"}, 64'(ctl), 64'(expCtl));
    checkOutput({tag, ".state"}, 64'(state_o), 64'(expState));
    checkOutput({tag, ".timeout"}, 64'(mem_timeout_o), 64'(expTo));
    checkOutput({tag, ".stallcnt"}, 64'(stall_cnt_o), 64'(expCnt));
    if (mem_timeout_o === 1'b1) pulses++;
    if (expCtl[8]) expCnt++;
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle();
    #3;
    checkOutput("reset.ctl", 64'(ctl), 64'(CTL_RESET));
    checkOutput("reset.state", 64'(state_o), 64'd0);
    checkOutput("reset.stallcnt", 64'(stall_cnt_o), 64'd0);
    checkOutput("reset.timeout", 64'(mem_timeout_o), 64'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b1;
    cycle("idle", CTL_NONE, 2'd0, 1'b0);

    // Load-use on rs2 and rs1, plus the cases that must not stall
    applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs2", CTL_LU, 2'd0, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("lu_x0", CTL_NONE, 2'd0, 1'b0);
    applyStimulus(5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs1", CTL_LU, 2'd0, 1'b0);
    applyStimulus(5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("lu_nouse", CTL_NONE, 2'd0, 1'b0);
    applyStimulus(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("lu_noload", CTL_NONE, 2'd0, 1'b0);

    // Redirect beats load-use
    applyStimulus(5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("redir_lu", CTL_FD, 2'd0, 1'b0);

    // Memory wait with a redirect held; the flush lands on the ready cycle
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("mw0", CTL_MEMW, 2'd0, 1'b0);
    cycle("mw1", CTL_MEMW, 2'd1, 1'b0);
    cycle("mw2", CTL_MEMW, 2'd1, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle("mw_ready", CTL_FD, 2'd1, 1'b0);
    idle();
    cycle("mw_done", CTL_NONE, 2'd0, 1'b0);

    // Trap followed by a two-cycle drain
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("trap", CTL_FD, 2'd0, 1'b0);
    idle();
    cycle("drain1", CTL_F, 2'd2, 1'b0);
    cycle("drain2", CTL_F, 2'd2, 1'b0);
    cycle("drain_end", CTL_NONE, 2'd0, 1'b0);

    // Trap and redirect together: the trap wins and starts a drain
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("trap_redir", CTL_FD, 2'd0, 1'b0);
    idle();
    cycle("tr_drain1", CTL_F, 2'd2, 1'b0);
    cycle("tr_drain2", CTL_F, 2'd2, 1'b0);
    cycle("tr_end", CTL_NONE, 2'd0, 1'b0);

    // Memory wait inside the drain freezes the count and extends it
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("tw_trap", CTL_FD, 2'd0, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("tw_wait", CTL_MEMW, 2'd2, 1'b0);
    idle();
    cycle("tw_resume", CTL_NONE, 2'd1, 1'b0);
    cycle("tw_drain1", CTL_F, 2'd2, 1'b0);
    cycle("tw_drain2", CTL_F, 2'd2, 1'b0);
    cycle("tw_end", CTL_NONE, 2'd0, 1'b0);

    // Second trap at the last drain cycle reloads the count
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("rl_trap", CTL_FD, 2'd0, 1'b0);
    idle();
    cycle("rl_drain1", CTL_F, 2'd2, 1'b0);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("rl_retrap", CTL_FD, 2'd2, 1'b0);
    idle();
    cycle("rl_drain2", CTL_F, 2'd2, 1'b0);
    cycle("rl_drain3", CTL_F, 2'd2, 1'b0);
    cycle("rl_end", CTL_NONE, 2'd0, 1'b0);

    // Ten-cycle wait: exactly one timeout pulse, five cycles after the wait starts
    pulses = 0;
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle($sformatf("to%0d", k), CTL_MEMW, (k == 0) ? 2'd0 : 2'd1, (k == 5));
    end
    idle();
    cycle("to_release", CTL_NONE, 2'd1, 1'b0);
    cycle("to_idle", CTL_NONE, 2'd0, 1'b0);
    checkOutput("to_pulses", 64'(pulses), 64'd1);

    // Asynchronous reset in the middle of a memory wait
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("ar_mw0", CTL_MEMW, 2'd0, 1'b0);
    cycle("ar_mw1", CTL_MEMW, 2'd1, 1'b0);
    rst_n_i = 1'b0;
    #1;
    checkOutput("ar.ctl", 64'(ctl), 64'(CTL_RESET));
    checkOutput("ar.state", 64'(state_o), 64'd0);
    checkOutput("ar.stallcnt", 64'(stall_cnt_o), 64'd0);
    @(posedge clk_i);
    #2;
    checkOutput("ar.hold_state", 64'(state_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
